// File: rtl/match_clock_pkg.sv
// match_clock_pkg
// Shared types and constants for the match clock.
//   clock_state_t : FSM state encoding (IDLE, RUN, PAUSED, OVER)
//   SEC_PER_MIN   : seconds per minute
//   MAX_MIN()     : largest minute value for a given BCD minute-digit count
//   MAX_TOTAL()   : largest total-seconds value for a given minute-digit count
package match_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } clock_state_t;

  localparam int SEC_PER_MIN = 60;

  function automatic int MAX_MIN(input int min_digits);
    int p;
    p = 1;
    for (int i = 0; i < min_digits; i++) p = p * 10;
    return p - 1;
  endfunction

  function automatic int MAX_TOTAL(input int min_digits);
    return MAX_MIN(min_digits) * SEC_PER_MIN + 59;
  endfunction

endpackage

// File: rtl/secs_to_bcd.sv
// secs_to_bcd
// Combinational conversion of a binary total-seconds value into BCD
// minutes and seconds digits.
//   total    : binary seconds, 0 .. MAX_TOTAL(MIN_DIGITS)
//   min_bcd  : BCD minutes, units digit in [3:0]
//   sec_tens : BCD seconds tens (0..5)
//   sec_ones : BCD seconds units
module secs_to_bcd
  import match_clock_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int TW         = 10
) (
  input  logic [TW-1:0]           total,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic [3:0]              sec_tens,
  output logic [3:0]              sec_ones
);

  always_comb begin
    int unsigned mins;
    int unsigned secs;
    mins     = 32'(total) / SEC_PER_MIN;
    secs     = 32'(total) % SEC_PER_MIN;
    sec_tens = 4'(secs / 10);
    sec_ones = 4'(secs % 10);
    min_bcd  = '0;
    // Peel minute digits off least-significant first.
    for (int i = 0; i < MIN_DIGITS; i++) begin
      min_bcd[4*i +: 4] = 4'(mins % 10);
      mins              = mins / 10;
    end
  end

endmodule

// File: rtl/match_clock.sv
// match_clock
// MM:SS match timer (countdown or stopwatch) with pause/resume, runtime
// load, bonus time, and a low-time warning with blink strobe.
// Ports:
//   clk, resetN          : clock, asynchronous active-low reset
//   one_sec              : one-cycle tick, once per second
//   count_up             : 0 = countdown, 1 = stopwatch (latched on start)
//   start/pause/restart  : control pulses (restart has top priority)
//   load, load_min/sec   : IDLE-only load of a new time (clamped)
//   add_bonus            : add BONUS_SEC in RUN/PAUSED (subtract in up mode)
//   running, game_over   : state == RUN, state == OVER
//   time_up              : one-cycle pulse with the first game_over cycle
//   warning, blink       : low-time indication and its per-tick strobe
//   secOnes/secTens/minDigs : BCD display digits
//   dbg_state            : current FSM state, for observation
// Control inputs are level-sampled pulses: each is acted on in every cycle
// it is high; there is no handshake or back-pressure.
module match_clock
  import match_clock_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int START_MIN  = 2,
  parameter int START_SEC  = 0,
  parameter int BONUS_SEC  = 10,
  parameter int WARN_SEC   = 10
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    one_sec,
  input  logic                    count_up,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    restart,
  input  logic                    load,
  input  logic [6:0]              load_min,
  input  logic [5:0]              load_sec,
  input  logic                    add_bonus,
  output logic                    running,
  output logic                    game_over,
  output logic                    time_up,
  output logic                    warning,
  output logic                    blink,
  output logic [3:0]              secOnes,
  output logic [3:0]              secTens,
  output logic [4*MIN_DIGITS-1:0] minDigs,
  output clock_state_t            dbg_state
);

  localparam int MAX    = MAX_TOTAL(MIN_DIGITS);
  localparam int MAXMIN = MAX_MIN(MIN_DIGITS);
  localparam int TW     = $clog2(MAX + 1);

  localparam logic [TW-1:0] MAX_T   = TW'(MAX);
  localparam logic [TW-1:0] START_T = TW'(START_MIN * SEC_PER_MIN + START_SEC);
  localparam logic [TW-1:0] BONUS_T = TW'(BONUS_SEC);
  localparam logic [TW-1:0] WARN_T  = TW'(WARN_SEC);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  clock_state_t  state_q, state_d;
  logic [TW-1:0] total_q, total_d;
  logic          up_q, up_d;
  logic          blink_q, blink_d;
  logic          time_up_q;

  logic [6:0]    lm_c;
  logic [5:0]    ls_c;
  logic [TW-1:0] load_total;
  logic [TW:0]   bonus_sum;
  logic [TW-1:0] t_bonus;
  logic [TW-1:0] t_adj;
  logic          warning_c;
  logic          tick_qual;

  // Clamped load value and the bonus-adjusted total used by RUN/PAUSED.
  always_comb begin
    lm_c       = (32'(load_min) > MAXMIN) ? 7'(MAXMIN) : load_min;
    ls_c       = (load_sec > 6'd59) ? 6'd59 : load_sec;
    load_total = TW'(lm_c) * TW'(SEC_PER_MIN) + TW'(ls_c);

    bonus_sum  = {1'b0, total_q} + {1'b0, BONUS_T};
    if (!up_q)
      t_bonus = (bonus_sum > {1'b0, MAX_T}) ? MAX_T : bonus_sum[TW-1:0];
    else
      t_bonus = (total_q > BONUS_T) ? (total_q - BONUS_T) : '0;
    t_adj = add_bonus ? t_bonus : total_q;
  end

  assign warning_c = !up_q && ((state_q == ST_RUN) || (state_q == ST_PAUSED)) &&
                     (total_q != '0) && (total_q <= WARN_T);

  // Next-state / next-total logic.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    up_d      = up_q;
    tick_qual = 1'b0;
    if (restart) begin
      state_d = ST_IDLE;
      total_d = START_T;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            total_d = load_total;
          end else if (start) begin
            up_d = count_up;
            // Nothing left to count: a down count from 0:00 or an up count
            // already at the ceiling ends immediately.
            if ((!count_up && total_q == '0) || (count_up && total_q == MAX_T))
              state_d = ST_OVER;
            else
              state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          total_d = t_adj;
          if (one_sec) begin
            tick_qual = warning_c;
            if (!up_q) begin
              if (t_adj != '0) total_d = t_adj - ONE_T;
              if (t_adj <= ONE_T) state_d = ST_OVER;
            end else begin
              if (t_adj != MAX_T) total_d = t_adj + ONE_T;
              if (t_adj >= MAX_T - ONE_T) state_d = ST_OVER;
            end
          end
          // Reaching OVER on the same cycle wins over a pause request.
          if (state_d == ST_RUN && pause) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          total_d = t_adj;
          if (start) state_d = ST_RUN;
        end
        ST_OVER: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Blink toggles per tick applied while warning is shown; it restarts
    // from 0 whenever the warning is not active.
    if (restart)        blink_d = 1'b0;
    else if (tick_qual) blink_d = ~blink_q;
    else if (!warning_c) blink_d = 1'b0;
    else                blink_d = blink_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      total_q   <= START_T;
      up_q      <= 1'b0;
      blink_q   <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      up_q      <= up_d;
      blink_q   <= blink_d;
      time_up_q <= (state_d == ST_OVER) && (state_q != ST_OVER);
    end
  end

  assign running   = (state_q == ST_RUN);
  assign game_over = (state_q == ST_OVER);
  assign time_up   = time_up_q;
  assign warning   = warning_c;
  assign blink     = blink_q & warning_c;
  assign dbg_state = state_q;

  secs_to_bcd #(
    .MIN_DIGITS (MIN_DIGITS),
    .TW         (TW)
  ) u_bcd (
    .total    (total_q),
    .min_bcd  (minDigs),
    .sec_tens (secTens),
    .sec_ones (secOnes)
  );

endmodule
